// File: rtl/multicycle_cpu.sv
// Four-register accumulator-style CPU with a FETCH/EXEC/MEM/HALT multicycle sequencer and
// req/ack instruction and data memory ports.
module multicycle_cpu #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 6,
    parameter int DADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic [DATA_W-1:0]  switches,
    input  logic [1:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         flags,
    output logic               halted
);

    localparam logic [1:0] StFetch = 2'd0;
    localparam logic [1:0] StExec  = 2'd1;
    localparam logic [1:0] StMem   = 2'd2;
    localparam logic [1:0] StHalt  = 2'd3;

    localparam logic [3:0] OpLdi  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpAddi = 4'h6;
    localparam logic [3:0] OpLd   = 4'h7;
    localparam logic [3:0] OpSt   = 4'h8;
    localparam logic [3:0] OpIn   = 4'h9;
    localparam logic [3:0] OpJmp  = 4'hA;
    localparam logic [3:0] OpJz   = 4'hB;
    localparam logic [3:0] OpJc   = 4'hC;
    localparam logic [3:0] OpJn   = 4'hD;
    localparam logic [3:0] OpCmp  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];

    logic [3:0]        opc;
    logic [1:0]        rd, rs;
    logic [DATA_W-1:0] imm_ext, op_a, op_b, alu_res, addr_sum;
    logic [DATA_W:0]   wide;
    logic              alu_c, alu_v;
    logic [3:0]        alu_flags;
    logic [PC_W-1:0]   jmp_tgt;

    assign opc      = ir_q[15:12];
    assign rd       = ir_q[11:10];
    assign rs       = ir_q[9:8];
    assign imm_ext  = DATA_W'(ir_q[7:0]);
    assign jmp_tgt  = PC_W'(ir_q[7:0]);
    assign op_a     = regs_q[rd];
    assign op_b     = (opc == OpAddi) ? imm_ext : regs_q[rs];
    assign addr_sum = regs_q[rs] + imm_ext;

    // Extra top bit of 'wide' carries the carry-out on add and the borrow on subtract.
    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opc)
            OpAdd, OpAddi: begin
                wide    = {1'b0, op_a} + {1'b0, op_b};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                alu_v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OpSub, OpCmp: begin
                wide    = {1'b0, op_a} - {1'b0, op_b};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                alu_v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            default: ;
        endcase
        alu_flags = {alu_res[DATA_W-1], alu_res == '0, alu_c, alu_v};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        regs_d  = regs_q;
        case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                case (opc)
                    OpLdi: regs_d[rd] = imm_ext;
                    OpAdd, OpSub, OpAnd, OpOr, OpAddi: begin
                        regs_d[rd] = alu_res;
                        flags_d    = alu_flags;
                    end
                    OpCmp:     flags_d = alu_flags;
                    OpIn:      regs_d[rd] = switches;
                    OpLd, OpSt: state_d = StMem;
                    OpJmp:     pc_d = jmp_tgt;
                    OpJz:      if (flags_q[2]) pc_d = jmp_tgt;
                    OpJc:      if (flags_q[1]) pc_d = jmp_tgt;
                    OpJn:      if (flags_q[3]) pc_d = jmp_tgt;
                    OpHalt:    state_d = StHalt;
                    default:   ;
                endcase
            end
            StMem: begin
                if (dmem_ack) begin
                    if (opc == OpLd) regs_d[rd] = dmem_rdata;
                    state_d = StFetch;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            regs_q  <= regs_d;
        end
    end

    // Reset is async, so gate the fetch request directly while it is held.
    assign imem_req   = (state_q == StFetch) && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == StMem);
    assign dmem_we    = (opc == OpSt);
    assign dmem_addr  = DADDR_W'(addr_sum);
    assign dmem_wdata = regs_q[rd];
    assign dbg_data   = regs_q[dbg_sel];
    assign pc         = pc_q;
    assign flags      = flags_q;
    assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: instruction-level reference model stepped on each fetch handshake,
// compared against the DUT every cycle, plus hand-computed checkpoints.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata = 16'hFFFF;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [3:0]  dmem_addr;
    logic [7:0]  dmem_wdata, dmem_rdata = 8'hC3;
    logic [7:0]  switches = 8'h3C;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;
    logic [5:0]  pc;
    logic [3:0]  flags;
    logic        halted;

    multicycle_cpu #(.DATA_W(8), .PC_W(6), .DADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .switches   (switches),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .pc         (pc),
        .flags      (flags),
        .halted     (halted)
    );

    always #20 clk = ~clk;

    logic [15:0] imem [64];
    logic [7:0]  dmem [16];
    logic [7:0]  mdl_mem [16];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int i_delay = 0, d_delay = 0, i_cnt = 0, d_cnt = 0;
    bit spur = 1'b0;

    logic [7:0] m_r [4];
    logic [5:0] m_pc;
    logic [3:0] m_flags;
    bit         m_halted, m_pend, m_we;
    logic [3:0] m_addr;
    logic [7:0] m_wdata;

    int         dreq_len = 0, last_len = 0;
    logic [3:0] last_addr;
    bit         last_we;
    logic [7:0] last_wdata;
    logic [5:0] last_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL timeout %s: got no event expected event (cycle %0d)", name, cyc);
    endtask

    task automatic read_reg(input int i, output logic [7:0] v);
        dbg_sel = 2'(i);
        #1;
        v = dbg_data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = 6'd0;
        m_flags = 4'h0;
        m_halted = 1'b0;
        m_pend = 1'b0;
    endtask

    // Flags {N,Z,C,V} from a plain integer result.
    function automatic logic [3:0] mk_flags(input int res, input bit c, input int sres);
        logic [7:0] r8;
        r8 = 8'(res);
        return {r8[7], r8 == 8'h00, c, (sres < -128) || (sres > 127)};
    endfunction

    function automatic int sgn(input int u);
        return (u > 127) ? u - 256 : u;
    endfunction

    task automatic model_step(input logic [15:0] ins);
        int op, rd, rs, a, b, imm, res;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:10]);
        rs  = int'(ins[9:8]);
        imm = int'(ins[7:0]);
        a   = int'(m_r[rd]);
        b   = int'(m_r[rs]);
        m_pc = m_pc + 6'd1;
        case (op)
            1: m_r[rd] = 8'(imm);
            2, 6: begin
                if (op == 6) b = imm;
                res = a + b;
                m_r[rd] = 8'(res);
                m_flags = mk_flags(res, res > 255, sgn(a) + sgn(b));
            end
            3, 14: begin
                res = a - b;
                if (op == 3) m_r[rd] = 8'(res);
                m_flags = mk_flags(res, a < b, sgn(a) - sgn(b));
            end
            4, 5: begin
                res = (op == 4) ? (a & b) : (a | b);
                m_r[rd] = 8'(res);
                m_flags = mk_flags(res, 1'b0, 0);
            end
            7, 8: begin
                m_pend = 1'b1;
                m_we = (op == 8);
                m_addr = 4'((b + imm) % 16);
                m_wdata = 8'(a);
                if (op == 7) m_r[rd] = mdl_mem[m_addr];
            end
            9:  m_r[rd] = switches;
            10: m_pc = 6'(imm);
            11: if (m_flags[2]) m_pc = 6'(imm);
            12: if (m_flags[1]) m_pc = 6'(imm);
            13: if (m_flags[3]) m_pc = 6'(imm);
            15: m_halted = 1'b1;
            default: ;
        endcase
    endtask

    // One clock: compare DUT against the model, then play both memories for this cycle.
    task automatic cycle();
        logic [7:0] v;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (imem_req) begin
                chk("fetch addr", 32'(imem_addr), 32'(m_pc));
                chk("flags at fetch", 32'(flags), 32'(m_flags));
                chk("no pending mem at fetch", 32'(m_pend), 0);
                for (int r = 0; r < 4; r++) begin
                    read_reg(r, v);
                    chk($sformatf("R%0d at fetch", r), 32'(v), 32'(m_r[r]));
                end
            end
            if (dmem_req) begin
                chk("dmem_req expected", 32'(m_pend), 1);
                chk("dmem_we", 32'(dmem_we), 32'(m_we));
                chk("dmem_addr", 32'(dmem_addr), 32'(m_addr));
                if (m_we) chk("dmem_wdata", 32'(dmem_wdata), 32'(m_wdata));
                chk("pc during mem", 32'(pc), 32'(m_pc));
            end
            if (halted) begin
                chk("halt expected", 32'(m_halted), 1);
                chk("pc held in halt", 32'(pc), 32'(m_pc));
            end
            if (m_halted) chk("no req after halt", 32'({imem_req, dmem_req}), 0);
        end
        if (reset) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
        end else begin
            if (imem_req) begin
                if (i_cnt >= i_delay) begin
                    imem_ack = 1'b1;
                    imem_rdata = imem[imem_addr];
                    model_step(imem[m_pc]);
                    i_cnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    imem_rdata = 16'hFFFF;
                    i_cnt++;
                end
            end else begin
                imem_ack = spur;
                imem_rdata = 16'hFFFF;
                i_cnt = 0;
            end
            if (dmem_req) begin
                dreq_len++;
                last_addr = dmem_addr;
                last_we = dmem_we;
                last_wdata = dmem_wdata;
                last_pc = pc;
                if (d_cnt >= d_delay) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    dmem_rdata = dmem[dmem_addr];
                    if (m_pend && m_we) mdl_mem[m_addr] = m_wdata;
                    m_pend = 1'b0;
                    last_len = dreq_len;
                    dreq_len = 0;
                    d_cnt = 0;
                end else begin
                    dmem_ack = 1'b0;
                    dmem_rdata = 8'hC3;
                    d_cnt++;
                end
            end else begin
                dmem_ack = spur;
                dmem_rdata = 8'hC3;
                d_cnt = 0;
                dreq_len = 0;
            end
        end
    endtask

    task automatic wait_fetch(input logic [5:0] a, input int budget, output int at);
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (imem_req && imem_addr == a) begin
                at = cyc;
                return;
            end
        end
        at = cyc;
        timeout_fail($sformatf("fetch of 0x%0h", a));
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
        case (p)
            1: begin
                imem[0] = 16'h14F0; imem[1] = 16'h1820; imem[2] = 16'h2600;
                imem[3] = 16'h1005; imem[4] = 16'h1C05; imem[5] = 16'h3300;
                imem[6] = 16'hB03F;
            end
            2: begin
                imem[0] = 16'h14A5; imem[1] = 16'h180E; imem[2] = 16'h8603;
                imem[3] = 16'h1004; imem[4] = 16'hE600; imem[5] = 16'h7C01;
                imem[6] = 16'h9800; imem[7] = 16'h4900; imem[8] = 16'hA00A;
                imem[9] = 16'hF000; imem[10] = 16'hF000;
            end
            default: begin
                imem[0] = 16'h1001; imem[1] = 16'h1402; imem[2] = 16'h2100;
                imem[3] = 16'h0000; imem[4] = 16'hF000;
            end
        endcase
    endtask

    task automatic do_reset(input int prog);
        logic [7:0] v;
        reset = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("reset imem_req", 32'(imem_req), 0);
        chk("reset dmem_req", 32'(dmem_req), 0);
        chk("reset pc", 32'(pc), 0);
        chk("reset flags", 32'(flags), 0);
        chk("reset halted", 32'(halted), 0);
        for (int r = 0; r < 4; r++) begin
            read_reg(r, v);
            chk($sformatf("reset R%0d", r), 32'(v), 0);
        end
        model_reset();
        load_prog(prog);
        i_cnt = 0;
        d_cnt = 0;
        dreq_len = 0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("imem_req after release", 32'(imem_req), 1);
        chk("imem_addr after release", 32'(imem_addr), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, n;
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            dmem[i] = 8'h00;
            mdl_mem[i] = 8'h00;
        end
        dmem[5] = 8'h7C;
        mdl_mem[5] = 8'h7C;

        // ADD carry, SUB to zero, JZ to top of memory and pc wrap.
        do_reset(1);
        wait_fetch(6'd3, 20, t0);
        read_reg(1, v); chk("ADD R1 result", 32'(v), 32'h10);
        chk("ADD flags", 32'(flags), 32'b0010);
        wait_fetch(6'd6, 20, t1);
        chk("3 ALU instr latency", 32'(t1 - t0), 6);
        wait_fetch(6'h3F, 20, t0);
        read_reg(0, v); chk("SUB R0 result", 32'(v), 32'h00);
        chk("SUB zero flags", 32'(flags), 32'b0100);
        wait_fetch(6'h00, 20, t1);
        chk("pc wrap fetch latency", 32'(t1 - t0), 2);

        // Reset during a withheld fetch.
        do_reset(1);
        wait_fetch(6'd2, 20, t0);
        i_delay = 50;
        wait_fetch(6'd3, 20, t0);
        cycle();
        read_reg(1, v); chk("R1 before abandon", 32'(v), 32'h10);
        i_delay = 0;
        // Reset during a withheld store.
        do_reset(2);
        d_delay = 50;
        n = 0;
        while (!dmem_req && n < 20) begin cycle(); n++; end
        chk("store reached mem", 32'(dmem_req), 1);
        cycle();
        do_reset(2);
        chk("abandoned store no write", 32'(dmem[1]), 32'h00);

        // Store with 3 wait cycles, load zero-wait, IN/AND, JMP, HALT; spurious acks throughout.
        d_delay = 3;
        spur = 1'b1;
        wait_fetch(6'd2, 20, t0);
        wait_fetch(6'd3, 20, t1);
        chk("store latency", 32'(t1 - t0), 6);
        chk("store req cycles", 32'(last_len), 4);
        chk("store addr wrap", 32'(last_addr), 32'h1);
        chk("store we", 32'(last_we), 1);
        chk("store wdata", 32'(last_wdata), 32'hA5);
        chk("pc during store wait", 32'(last_pc), 32'h3);
        chk("store landed", 32'(dmem[1]), 32'hA5);
        d_delay = 0;
        wait_fetch(6'd5, 20, t0);
        wait_fetch(6'd6, 20, t1);
        chk("load latency", 32'(t1 - t0), 3);
        read_reg(3, v); chk("LD R3", 32'(v), 32'h7C);
        chk("flags kept by LD", 32'(flags), 32'b1000);
        n = 0;
        while (!halted && n < 40) begin cycle(); n++; end
        chk("prog2 halted", 32'(halted), 1);
        chk("prog2 halt pc", 32'(pc), 32'h0B);
        read_reg(2, v); chk("AND R2", 32'(v), 32'h24);
        chk("model R2", 32'(m_r[2]), 32'h24);
        chk("model R3", 32'(m_r[3]), 32'h7C);
        chk("AND flags", 32'(flags), 32'b0000);
        spur = 1'b0;

        // HALT at address 4.
        do_reset(4);
        wait_fetch(6'd4, 20, t0);
        n = 0;
        while (!halted && n < 10) begin cycle(); n++; end
        chk("halt latency", 32'(n), 2);
        repeat (8) cycle();
        chk("halted held", 32'(halted), 1);
        chk("halt pc", 32'(pc), 32'h05);
        chk("no fetch in halt", 32'(imem_req), 0);
        read_reg(0, v); chk("prog4 R0", 32'(v), 32'h03);
        t2 = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath/register width (legal 8..32); imm8 zero-extended to DATA_W.
REQ-002 SHALL have parameter PC_W, default 6, instruction address width.
REQ-003 SHALL have parameter DADDR_W, default 4, data address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  PC_W  fetch address (equals pc).
REQ-008 imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  input  16  instruction: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-010 dmem_req  output  1  data access request.
REQ-011 dmem_we  output  1  1=store, 0=load; valid while dmem_req=1.
REQ-012 dmem_addr  output  DADDR_W  (R[rs]+imm) truncated to DADDR_W (wraps).
REQ-013 dmem_wdata  output  DATA_W  store data R[rd].
REQ-014 dmem_ack  input  1  data access complete; dmem_rdata valid in the same cycle for loads.
REQ-015 dmem_rdata  input  DATA_W  load data.
REQ-016 switches  input  DATA_W  external input port, read by IN.
REQ-017 dbg_sel  input  2  register index for debug read.
REQ-018 dbg_data  output  DATA_W  combinational R[dbg_sel].
REQ-019 pc  output  PC_W  current program counter.
REQ-020 flags  output  4  {N,Z,C,V}.
REQ-021 halted  output  1  high in HALT state.

Function
REQ-022 Four registers R0..R3, DATA_W wide, none hardwired.
REQ-023 FSM states FETCH, EXEC, MEM, HALT; FETCH->EXEC on imem_ack; EXEC->MEM for LD/ST, ->HALT for HALT, else ->FETCH; MEM->FETCH on dmem_ack; HALT is terminal until reset.
REQ-024 Handshake: req held high with address/we/wdata stable until ack sampled high on a rising edge; req low in the following cycle; zero-wait ack (ack high in first req cycle) legal.
REQ-025 ack received while the matching req is low SHALL be ignored.
REQ-026 On fetch completion: IR <= imem_rdata, pc <= pc+1 mod 2^PC_W.
REQ-027 Latency with zero-wait memories: 2 cycles per non-memory instruction, 3 cycles per LD/ST; each ack wait cycle adds 1 cycle.
REQ-028 Opcodes: 0 NOP; 1 LDI rd<=imm; 2 ADD rd<=rd+rs; 3 SUB rd<=rd-rs; 4 AND; 5 OR; 6 ADDI rd<=rd+imm; 7 LD rd<=mem[rs+imm]; 8 ST mem[rs+imm]<=rd; 9 IN rd<=switches; A JMP; B JZ; C JC; D JN; E CMP (rd-rs, flags only); F HALT.
REQ-029 Arithmetic modulo 2^DATA_W; ADD/ADDI C=carry-out; SUB/CMP C=1 on unsigned borrow (rd<rs); V=two's-complement overflow; AND/OR C=0, V=0; Z=(result==0); N=result MSB.
REQ-030 Flags SHALL update in EXEC only for opcodes 2,3,4,5,6,E; all other opcodes leave flags unchanged.
REQ-031 Jumps in EXEC: pc <= imm[PC_W-1:0] when unconditional or flag (Z/C/N) set; otherwise pc keeps its incremented value.
REQ-032 Register writeback in EXEC for 1..6,9; LD writes rd on dmem_ack cycle; rd==rs SHALL use pre-instruction operand values.
REQ-033 dbg_data SHALL reflect register state with no added latency, including a write on the same edge from the next cycle.

Reset
REQ-034 On reset assertion, immediately: state=FETCH (imem_req low while reset high), pc=0, R0..R3=0, flags=0, dmem_req=0, imem_req=0, halted=0.
REQ-035 Reset during an outstanding fetch or data access SHALL abandon it; no register, flag or memory-side effect from the abandoned instruction.
REQ-036 After reset deasserts, imem_req SHALL go high in the first cycle with imem_addr=0.

Verification
REQ-037 LDI R1,0xF0; LDI R2,0x20; ADD R1,R2 -> R1=0x10, flags N=0 Z=0 C=1 V=0.
REQ-038 LDI R0,5; LDI R3,5; SUB R0,R3; JZ 0x3F -> R0=0, Z=1, next imem_addr=0x3F; following fetch advances pc to 0x00 (wrap).
REQ-039 ST R1,[R2+3] with R1=0xA5, R2=0x0E, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_addr=0x1 (wrap), dmem_we=1, wdata=0xA5 stable; pc unchanged during wait.
REQ-040 LD R3,[R0+1] with dmem_rdata=0x7C on zero-wait ack -> R3=0x7C after 3 cycles, flags unchanged.
REQ-041 Assert reset while imem_req high, ack withheld -> imem_req low immediately, pc=0, registers 0; fetch from 0 restarts after release.
REQ-042 HALT at address 4 -> halted=1 one cycle after EXEC, no further imem_req/dmem_req, pc=5 held until reset.
